// File: rtl/lcd_seq_pkg.sv
// Shared types and default timing for the LCD power sequencer.
// Defaults match the production panel (2500x560 generator totals).
package lcd_seq_pkg;

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_PWR  = 3'd1,
        S_WARM = 3'd2,
        S_RUN  = 3'd3,
        S_DARK = 3'd4
    } seq_state_t;

    localparam int unsigned DEF_T_PWR_CYC   = 20000;
    localparam int unsigned DEF_T_OFF_CYC   = 50000;
    localparam int unsigned DEF_WARM_FRAMES = 2;
    localparam int unsigned DEF_DARK_FRAMES = 1;
    localparam int unsigned DEF_X_TOTAL     = 2500;
    localparam int unsigned DEF_Y_TOTAL     = 560;

    localparam logic [23:0] BLACK_PX = 24'h000000;

    // Frame counts must fit the 8-bit frame counter and be non-zero.
    function automatic bit frames_ok(input int unsigned n);
        return (n >= 1) && (n <= 255);
    endfunction

endpackage

// File: rtl/lcd_frame_detect.sv
// Registered one-cycle pulse when the generator sits on its last pixel.
// Gated by the begin flag so an idle (held at 0,0) generator never pulses.
module lcd_frame_detect
    import lcd_seq_pkg::*;
#(
    parameter int unsigned X_TOTAL = DEF_X_TOTAL,
    parameter int unsigned Y_TOTAL = DEF_Y_TOTAL
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        begin_i,
    input  logic [15:0] xpx_i,
    input  logic [15:0] ypx_i,
    output logic        frame_end_o
);

    localparam logic [15:0] X_LAST = 16'(X_TOTAL - 1);
    localparam logic [15:0] Y_LAST = 16'(Y_TOTAL - 1);

    logic fe_q;
    logic fe_d;

    always_comb begin
        fe_d = begin_i && (xpx_i == X_LAST) && (ypx_i == Y_LAST);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fe_q <= 1'b0;
        end else begin
            fe_q <= fe_d;
        end
    end

    assign frame_end_o = fe_q;

endmodule

// File: rtl/lcd_power_sequencer.sv
// Panel power / generator start / blanking / backlight sequencer; all outputs registered.
// Optional frame watchdog with o_Fault when LCD_SEQ_WATCHDOG_EN is defined.
module lcd_power_sequencer
    import lcd_seq_pkg::*;
#(
    parameter int unsigned T_PWR_CYC   = DEF_T_PWR_CYC,
    parameter int unsigned T_OFF_CYC   = DEF_T_OFF_CYC,
    parameter int unsigned WARM_FRAMES = DEF_WARM_FRAMES,
    parameter int unsigned DARK_FRAMES = DEF_DARK_FRAMES,
    parameter int unsigned X_TOTAL     = DEF_X_TOTAL,
    parameter int unsigned Y_TOTAL     = DEF_Y_TOTAL
) (
    input  logic        i_CLK,
    input  logic        i_Reset,
    input  logic        i_Enable,
    input  logic [15:0] i_XPx,
    input  logic [15:0] i_YPx,
    output logic        o_PanelPwr,
    output logic        o_Begin,
    output logic        o_Blank,
    output logic        o_Backlight,
    output logic        o_Ready,
    output logic        o_FrameEnd
`ifdef LCD_SEQ_WATCHDOG_EN
    ,
    output logic        o_Fault
`endif
);

    if (!frames_ok(WARM_FRAMES) || !frames_ok(DARK_FRAMES)) begin : g_bad_frames
        $error("lcd_power_sequencer: WARM_FRAMES and DARK_FRAMES must be in 1..255");
    end

    localparam logic [31:0] PWR_LAST  = 32'(T_PWR_CYC - 1);
    localparam logic [31:0] OFF_LAST  = 32'(T_OFF_CYC - 1);
    localparam logic [7:0]  WARM_LAST = 8'(WARM_FRAMES - 1);
    localparam logic [7:0]  DARK_LAST = 8'(DARK_FRAMES - 1);

    seq_state_t  state_q, state_d;
    logic [31:0] cyc_q, cyc_d;
    logic [7:0]  frm_q, frm_d;
    logic        pwr_q, pwr_d;
    logic        begin_q, begin_d;
    logic        blank_q, blank_d;
    logic        bl_q, bl_d;
    logic        rdy_q, rdy_d;
    logic        frame_end;
    logic        state_chg;
    logic        fault_now;
    logic        wd_expired;

    lcd_frame_detect #(
        .X_TOTAL (X_TOTAL),
        .Y_TOTAL (Y_TOTAL)
    ) u_frame_detect (
        .clk_i       (i_CLK),
        .rst_i       (i_Reset),
        .begin_i     (begin_q),
        .xpx_i       (i_XPx),
        .ypx_i       (i_YPx),
        .frame_end_o (frame_end)
    );

`ifdef LCD_SEQ_WATCHDOG_EN
    localparam logic [31:0] WD_LAST = 32'(2 * X_TOTAL * Y_TOTAL - 1);

    logic [31:0] wdt_q, wdt_d;
    logic        fault_q, fault_d;
    logic        wd_active;

    assign wd_active  = (state_q == S_WARM) || (state_q == S_RUN) || (state_q == S_DARK);
    assign wd_expired = wd_active && (wdt_q == WD_LAST);
    assign fault_now  = fault_q;

    always_comb begin
        wdt_d   = wdt_q;
        fault_d = fault_q | (wd_expired && (state_q != S_DARK));
        if (state_chg || frame_end || !wd_active) begin
            wdt_d = '0;
        end else if (wdt_q != WD_LAST) begin
            wdt_d = wdt_q + 32'd1;
        end
    end

    always_ff @(posedge i_CLK or posedge i_Reset) begin
        if (i_Reset) begin
            wdt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            wdt_q   <= wdt_d;
            fault_q <= fault_d;
        end
    end

    assign o_Fault = fault_q;
`else
    assign wd_expired = 1'b0;
    assign fault_now  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_OFF: begin
                if (!fault_now && i_Enable && (cyc_q >= OFF_LAST)) begin
                    state_d = S_PWR;
                end
            end
            S_PWR: begin
                if (!i_Enable) begin
                    state_d = S_OFF;
                end else if (cyc_q >= PWR_LAST) begin
                    state_d = S_WARM;
                end
            end
            S_WARM: begin
                if (!i_Enable || wd_expired) begin
                    state_d = S_DARK;
                end else if (frame_end && (frm_q == WARM_LAST)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!i_Enable || wd_expired) begin
                    state_d = S_DARK;
                end
            end
            S_DARK: begin
                // After a fault, a dead generator must not trap us with power on.
                if ((frame_end && (frm_q == DARK_LAST)) || (fault_now && wd_expired)) begin
                    state_d = S_OFF;
                end
            end
            default: state_d = S_OFF;
        endcase
    end

    assign state_chg = (state_d != state_q);

    always_comb begin
        cyc_d = cyc_q;
        frm_d = frm_q;
        if (state_chg) begin
            cyc_d = '0;
            frm_d = '0;
        end else begin
            if (cyc_q != 32'hFFFF_FFFF) begin
                cyc_d = cyc_q + 32'd1;
            end
            if (frame_end && (frm_q != 8'hFF)) begin
                frm_d = frm_q + 8'd1;
            end
        end
    end

    always_comb begin
        pwr_d   = (state_d != S_OFF);
        begin_d = begin_q | (state_d == S_WARM);
        blank_d = (state_d != S_RUN);
        bl_d    = (state_d == S_RUN);
        rdy_d   = (state_d == S_RUN);
    end

    always_ff @(posedge i_CLK or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= S_OFF;
            cyc_q   <= '0;
            frm_q   <= '0;
            pwr_q   <= 1'b0;
            begin_q <= 1'b0;
            blank_q <= 1'b1;
            bl_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            frm_q   <= frm_d;
            pwr_q   <= pwr_d;
            begin_q <= begin_d;
            blank_q <= blank_d;
            bl_q    <= bl_d;
            rdy_q   <= rdy_d;
        end
    end

    assign o_PanelPwr  = pwr_q;
    assign o_Begin     = begin_q;
    assign o_Blank     = blank_q;
    assign o_Backlight = bl_q;
    assign o_Ready     = rdy_q;
    assign o_FrameEnd  = frame_end;

endmodule
